// File: rtl/twiddle_rotator_inv_32b_if.sv
// twiddle_rotator_inv_32b_if: sample-in / result-out handshake bundle for the inverse twiddle rotator
interface twiddle_rotator_inv_32b_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A32;
  logic [5:0]  K6;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] R32;
  logic [5:0]  out_k;
  modport master (output in_valid, A32, K6, out_ready, input in_ready, out_valid, R32, out_k);
  modport slave  (input in_valid, A32, K6, out_ready, output in_ready, out_valid, R32, out_k);
endinterface

// File: rtl/twiddle_rotator_inv_32b.sv
// twiddle_rotator_inv_32b: 3-stage pipelined Q1.15 complex rotation by e^(+j2pi k/64) with valid/ready stalling
module twiddle_rotator_inv_32b (
  input logic clk,
  input logic rst,
  twiddle_rotator_inv_32b_if.slave bus
);
  logic stall;
  logic v1_q, v2_q, v3_q, byp2_q;
  logic [5:0] k1_q, k2_q, k3_q;
  logic [31:0] a1_q, bv2_q, r3_q, bv_d, r_d;
  logic [15:0] t_r, t_c, nre1, nim1;
  logic signed [15:0] c_d, s_d, c1_q, s1_q, re1, im1;
  logic signed [31:0] prc_q, pis_q, prs_q, pic_q;
  // quarter-wave table: round(32768*sin(2*pi*i/64)), top entry clipped to 32767
  function automatic logic [15:0] tq(input logic [4:0] i);
    case (i)
      5'd0: tq = 16'd0;
      5'd1: tq = 16'd3212;
      5'd2: tq = 16'd6393;
      5'd3: tq = 16'd9512;
      5'd4: tq = 16'd12540;
      5'd5: tq = 16'd15447;
      5'd6: tq = 16'd18205;
      5'd7: tq = 16'd20788;
      5'd8: tq = 16'd23170;
      5'd9: tq = 16'd25330;
      5'd10: tq = 16'd27246;
      5'd11: tq = 16'd28899;
      5'd12: tq = 16'd30274;
      5'd13: tq = 16'd31357;
      5'd14: tq = 16'd32138;
      5'd15: tq = 16'd32610;
      default: tq = 16'd32767;
    endcase
  endfunction
  function automatic logic [15:0] nsat(input logic [15:0] x);
    return x == 16'h8000 ? 16'h7fff : -x;
  endfunction
  function automatic logic [15:0] rsat(input logic signed [32:0] x);
    logic signed [32:0] r;
    r = (x + 33'sd16384) >>> 15;
    return r > 33'sd32767 ? 16'h7fff : r < -33'sd32768 ? 16'h8000 : r[15:0];
  endfunction
  assign stall = v3_q & ~bus.out_ready;
  assign re1 = a1_q[31:16];
  assign im1 = a1_q[15:0];
  assign nre1 = nsat(a1_q[31:16]);
  assign nim1 = nsat(a1_q[15:0]);
  // cos/sin of the full circle folded onto the first quadrant
  always_comb begin
    t_r = tq({1'b0, bus.K6[3:0]});
    t_c = tq(5'd16 - {1'b0, bus.K6[3:0]});
    c_d = bus.K6[5:4] == 2'd0 ? t_c : bus.K6[5:4] == 2'd1 ? -t_r : bus.K6[5:4] == 2'd2 ? -t_c : t_r;
    s_d = bus.K6[5:4] == 2'd0 ? t_r : bus.K6[5:4] == 2'd1 ? t_c : bus.K6[5:4] == 2'd2 ? -t_r : -t_c;
    bv_d = k1_q[5:4] == 2'd0 ? a1_q : k1_q[5:4] == 2'd1 ? {nim1, a1_q[31:16]} :
           k1_q[5:4] == 2'd2 ? {nre1, nim1} : {a1_q[15:0], nre1};
    r_d = byp2_q ? bv2_q : {rsat({prc_q[31], prc_q} - {pis_q[31], pis_q}),
                            rsat({prs_q[31], prs_q} + {pic_q[31], pic_q})};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      r3_q <= '0;
      k3_q <= '0;
    end else if (!stall) begin
      v1_q <= bus.in_valid;
      a1_q <= bus.A32;
      k1_q <= bus.K6;
      c1_q <= c_d;
      s1_q <= s_d;
      v2_q <= v1_q;
      k2_q <= k1_q;
      byp2_q <= k1_q[3:0] == 4'd0;
      bv2_q <= bv_d;
      prc_q <= 32'(re1) * 32'(c1_q);
      pis_q <= 32'(im1) * 32'(s1_q);
      prs_q <= 32'(re1) * 32'(s1_q);
      pic_q <= 32'(im1) * 32'(c1_q);
      v3_q <= v2_q;
      k3_q <= k2_q;
      r3_q <= r_d;
    end
  end
  assign bus.in_ready = ~stall;
  assign bus.out_valid = v3_q;
  assign bus.R32 = r3_q;
  assign bus.out_k = k3_q;
endmodule

// File: tb/tb_twiddle_rotator_inv_32b.sv
// tb_twiddle_rotator_inv_32b: directed and random checks of the rotator against a real-arithmetic reference
module tb_twiddle_rotator_inv_32b;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tot = 0;
  int n_bad = 0;
  logic [37:0] exp_q[$];
  logic stall_p = 1'b0;
  logic [38:0] held;
  twiddle_rotator_inv_32b_if bus ();
  twiddle_rotator_inv_32b dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] sat16(input longint x);
    return x > 32767 ? 16'h7fff : x < -32768 ? 16'h8000 : x[15:0];
  endfunction
  function automatic int tw(input real x);
    int v;
    v = $rtoi($floor(32768.0 * x + 0.5));
    return v > 32767 ? 32767 : v;
  endfunction
  function automatic logic [31:0] model(input logic [31:0] a, input logic [5:0] k);
    longint re, im, c, s;
    real ang;
    re = longint'($signed(a[31:16]));
    im = longint'($signed(a[15:0]));
    if (k % 16 == 0)
      case (k / 16)
        0: return a;
        1: return {sat16(-im), sat16(re)};
        2: return {sat16(-re), sat16(-im)};
        default: return {sat16(im), sat16(-re)};
      endcase
    ang = 2.0 * 3.14159265358979 * real'(k) / 64.0;
    c = longint'(tw($cos(ang)));
    s = longint'(tw($sin(ang)));
    return {sat16((re * c - im * s + 16384) >>> 15), sat16((re * s + im * c + 16384) >>> 15)};
  endfunction
  task automatic cyc(input logic iv, input logic [31:0] a, input logic [5:0] k, input logic ordy,
                     input logic r = 1'b0, input logic use_e = 1'b0, input logic [31:0] e = 32'd0);
    @(negedge clk);
    rst = r;
    bus.in_valid = iv;
    bus.A32 = a;
    bus.K6 = k;
    bus.out_ready = ordy;
    #1;
    if (stall_p) chk("hold", {bus.out_valid, bus.out_k, bus.R32}, held);
    if (!r && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("extra", exp_q.size(), 1);
      else chk("out", {bus.out_k, bus.R32}, exp_q.pop_front());
    end
    if (!r && iv && bus.in_ready) exp_q.push_back({k, use_e ? e : model(a, k)});
    if (r) exp_q.delete();
    stall_p = !r && bus.out_valid && !bus.out_ready;
    held = {bus.out_valid, bus.out_k, bus.R32};
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc(1'b0, 32'd0, 6'd0, 1'b1);
    chk("drain", exp_q.size(), 0);
  endtask
  function automatic logic [15:0] pick();
    logic [15:0] corner[4] = '{16'h8000, 16'h7fff, 16'h0000, 16'hffff};
    return $urandom_range(0, 2) == 0 ? corner[$urandom_range(0, 3)] : 16'($urandom);
  endfunction
  initial begin
    bus.in_valid = 1'b0;
    bus.A32 = '0;
    bus.K6 = '0;
    bus.out_ready = 1'b1;
    cyc(1'b0, 32'd0, 6'd0, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 6'd0, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 6'd0, 1'b1);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_r", bus.R32, 0);
    chk("rst_k", bus.out_k, 0);
    chk("rst_ir", bus.in_ready, 1);
    // identity with exact latency
    cyc(1'b1, 32'h4000_2000, 6'd0, 1'b1, 1'b0, 1'b1, 32'h4000_2000);
    cyc(1'b0, 32'd0, 6'd0, 1'b1);
    chk("lat1", bus.out_valid, 0);
    cyc(1'b0, 32'd0, 6'd0, 1'b1);
    chk("lat2", bus.out_valid, 0);
    cyc(1'b0, 32'd0, 6'd0, 1'b1);
    chk("id_ov", bus.out_valid, 1);
    chk("id_r", bus.R32, 32'h4000_2000);
    chk("id_k", bus.out_k, 0);
    cyc(1'b1, 32'h4000_2000, 6'd16, 1'b1, 1'b0, 1'b1, 32'he000_4000);
    cyc(1'b1, 32'h4000_0000, 6'd8, 1'b1, 1'b0, 1'b1, 32'h2d41_2d41);
    cyc(1'b1, 32'h8000_0001, 6'd32, 1'b1, 1'b0, 1'b1, 32'h7fff_ffff);
    cyc(1'b1, 32'h8000_8000, 6'd48, 1'b1, 1'b0, 1'b1, 32'h8000_7fff);
    drain();
    // backpressure
    for (int i = 1; i <= 3; i++) cyc(1'b1, {16'(i), 16'(i)}, 6'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'hdead_beef, 6'd5, 1'b0);
      chk("bp_ir", bus.in_ready, 0);
      chk("bp_r", bus.R32, 32'h0001_0001);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 32'd0, 6'd0, 1'b1);
      chk("bp_rel", {bus.out_valid, bus.R32}, {1'b1, 16'(i), 16'(i)});
    end
    drain();
    // reset with samples in flight
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 6'($urandom), 1'b1);
    cyc(1'b1, 32'h1234_5678, 6'd3, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 6'd0, 1'b1);
    chk("mr_ov", bus.out_valid, 0);
    chk("mr_r", bus.R32, 0);
    chk("mr_ir", bus.in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'd0, 6'd0, 1'b1);
      chk("mr_gone", bus.out_valid, 0);
    end
    // random traffic with random backpressure
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 9) < 7, {pick(), pick()},
          $urandom_range(0, 3) == 0 ? {2'($urandom), 4'd0} : 6'($urandom), $urandom_range(0, 9) < 6);
    drain();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/twiddle_rotator_inv_32b.md
TWIDDLE_ROTATOR_INV_32B -- requirements
Module: twiddle_rotator_inv_32b

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-002 The ports SHALL be, in order:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  A32 and K6 hold a sample.
- in_ready  out  1  block accepts a sample this cycle.
- A32  in  32  {real[31:16], imag[15:0]}, each 16-bit two's complement Q1.15.
- K6  in  6  twiddle index k, 0..63.
- out_valid  out  1  R32 and out_k hold a result.
- out_ready  in  1  downstream accepts the result.
- R32  out  32  {real[31:16], imag[15:0]}, Q1.15.
- out_k  out  6  the k that travelled with this result.

Function
REQ-003 The block SHALL compute R = A × e^(+j2πk/64), which is the inverse-direction (conjugate) rotation of the forward FFT twiddle W64^k.
REQ-004 A sample SHALL transfer in when in_valid and in_ready are both 1; a result SHALL transfer out when out_valid and out_ready are both 1.
REQ-005 The pipeline SHALL have three register stages: S1 captures the input and looks up the twiddle; S2 forms the products; S3 sums, rounds, saturates and drives R32, out_k and out_valid.
REQ-006 Latency from input transfer to out_valid SHALL be 3 cycles with no stall; throughput SHALL be one sample per cycle.
REQ-007 The stall signal SHALL be stall = out_valid & ~out_ready.
REQ-008 in_ready SHALL equal ~stall.
REQ-009 While stall is 1, every stage (data, k and valid bits) SHALL hold its value.
REQ-010 While stall is 1, R32, out_k and out_valid SHALL remain bit-stable.
REQ-011 Bubbles (stages with valid 0) SHALL propagate without stalling; a valid bit SHALL clear when its stage advances with no incoming sample.
REQ-012 Twiddle values SHALL come from a 17-entry quarter-wave table T[i] = min(round(32768·sin(2πi/64)), 32767), i = 0..16.
REQ-013 For general k, c = cos(2πk/64) and s = sin(2πk/64) SHALL be derived from T by quadrant symmetry.
REQ-014 Example table entries: T[8] = 23170, T[16] = 32767.
REQ-015 For general k, the block SHALL compute re' = re·c − im·s and im' = re·s + im·c.
REQ-016 In REQ-015, products SHALL be 32-bit signed and each sum SHALL be at least 33-bit signed.
REQ-017 Rounding SHALL add 2^14 and then arithmetic-shift right by 15, i.e. round half up.
REQ-018 After rounding, each component SHALL saturate to [−32768, 32767].
REQ-019 Trivial indices SHALL bypass the multipliers and be exact, with the same 3-cycle latency:
- k = 0: (re, im)
- k = 16: (−im, re)
- k = 32: (−re, −im)
- k = 48: (im, −re)
REQ-020 Negating −32768 in a bypass path SHALL saturate to 32767.
REQ-021 Result ordering SHALL equal input ordering, with no loss or duplication under any out_ready pattern.
REQ-022 in_valid and out_ready asserted in the same cycle as stall deasserts SHALL both take effect in that cycle, i.e. a simultaneous transfer in and out.
REQ-023 A32 and K6 SHALL be ignored whenever in_valid is 0.

Reset
REQ-024 When rst is 1 at a clock edge, all stage valid bits, out_valid, R32 and out_k SHALL become 0 at that edge, regardless of stall or in-flight data.
REQ-025 in_ready SHALL be 1 in the cycle after reset.
REQ-026 Samples in flight at reset SHALL be discarded and never appear at the output.
REQ-027 Reset SHALL take priority over a transfer in the same cycle.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Identity: k=0, A32=0x4000_2000, out_ready=1 → R32=0x4000_2000, out_k=0, exactly 3 cycles after acceptance.
- ×j: k=16, A32=0x4000_2000 → R32=0xE000_4000.
- 45°: k=8, A32=0x4000_0000 → R32=0x2D41_2D41 (16384·23170/32768 = 11585).
- Saturation: k=32, A32=0x8000_0001 → R32=0x7FFF_FFFF.
- Backpressure: issue k=0 samples 0x0001_0001, 0x0002_0002, 0x0003_0003 back-to-back, then drop out_ready for 4 cycles → in_ready=0 and R32 held at 0x0001_0001 throughout; on release, the three results appear in order on consecutive cycles.
- Reset mid-stream: rst with 3 samples in flight → next cycle out_valid=0, R32=0, in_ready=1; none of the discarded samples ever emerge.
